// File: rtl/seq_maze_pkg.sv
// Shared types and constants for the sequence-maze monitor.
//   state_e    : monitor states (run, done, trapped, failed)
//   zone_idx_t : index of one zone-request bit (up to 32 zones)
//   DefaultSeq : default lap order, zones 0,1,2,3,4 (entry k is lap step k)
package seq_maze_pkg;

  typedef enum logic [1:0] {
    StRun,
    StDone,
    StTrapped,
    StFailed
  } state_e;

  typedef logic [4:0] zone_idx_t;

  localparam int unsigned DefaultSeqLen = 5;

  // Entry 0 sits in the least-significant slot.
  localparam zone_idx_t [DefaultSeqLen-1:0] DefaultSeq = {5'd4, 5'd3, 5'd2, 5'd1, 5'd0};

endpackage

// File: rtl/seq_maze_req_if.sv
// Bundle of environment/zone inputs and monitor outputs for seq_maze_req.
//   iupdown, ileftright : environment inputs, observed only
//   controllable_zone   : one request bit per zone
//   objective, error    : monitor status flags
//   progress, lap       : steps and laps completed
// master drives the inputs (environment side); slave is the monitor.
interface seq_maze_req_if #(
  parameter int unsigned NZONES = 6,
  parameter int unsigned PW     = 4,
  parameter int unsigned LW     = 2
);

  logic              iupdown;
  logic              ileftright;
  logic [NZONES-1:0] controllable_zone;
  logic              objective;
  logic              error;
  logic [PW-1:0]     progress;
  logic [LW-1:0]     lap;

  modport master (
    output iupdown,
    output ileftright,
    output controllable_zone,
    input  objective,
    input  error,
    input  progress,
    input  lap
  );

  modport slave (
    input  iupdown,
    input  ileftright,
    input  controllable_zone,
    output objective,
    output error,
    output progress,
    output lap
  );

endinterface

// File: rtl/seq_maze_timer.sv
// Per-step timeout counter for seq_maze_req; only instantiated when
// SEQ_MAZE_TIMEOUT_EN is defined.
//   clk, rst  : clock, synchronous active-high reset
//   run_i     : monitor is in the run state (counter advances)
//   clear_i   : a step was completed this cycle (counter restarts)
//   expired_o : this is the TIMEOUT-th idle cycle of the current step
module seq_maze_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter holds the number of idle cycles already spent, so the
  // cycle that sees TIMEOUT-1 is the one whose edge would reach TIMEOUT.
  assign expired_o = run_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/seq_maze_req.sv
// Sequence-maze monitor: tracks zone requests against a fixed lap order,
// raises objective after LAPS full laps, and traps on TRAP_ZONE.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_maze_req_if.slave (zone/environment inputs, status outputs)
// Optional feature: define SEQ_MAZE_TIMEOUT_EN to add a per-step timeout
// that moves the monitor to the failed state after TIMEOUT idle cycles.
module seq_maze_req
  import seq_maze_pkg::*;
#(
  parameter int unsigned              NZONES    = 6,
  parameter int unsigned              SEQ_LEN   = 5,
  parameter int unsigned              LAPS      = 2,
  parameter zone_idx_t [SEQ_LEN-1:0]  SEQ       = DefaultSeq,
  parameter int unsigned              TRAP_ZONE = 5,
  parameter int unsigned              TIMEOUT   = 64
) (
  input logic           clk,
  input logic           rst,
  seq_maze_req_if.slave bus
);

  localparam int unsigned Total   = SEQ_LEN * LAPS;
  localparam int unsigned PW      = $clog2(Total + 1);
  localparam int unsigned LW      = $clog2(LAPS + 1);
  localparam int unsigned SW      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam zone_idx_t   TrapIdx = zone_idx_t'(TRAP_ZONE);

  state_e        state_q, state_d;
  logic [PW-1:0] progress_q, progress_d;
  logic [LW-1:0] lap_q, lap_d;
  // Step within the current lap, i.e. progress mod SEQ_LEN kept explicitly.
  logic [SW-1:0] step_q, step_d;

  logic [31:0] zone_ext;
  logic        running;
  logic        advance;
  logic        trap;
  logic        expired;
  logic        unused_env;

  // Environment inputs carry no state; fold them so they are visibly consumed.
  assign unused_env = ^{bus.iupdown, bus.ileftright};

  // Widen to 32 so any 5-bit zone index selects a defined bit.
  always_comb begin
    zone_ext               = '0;
    zone_ext[NZONES-1:0]   = bus.controllable_zone;
  end

  assign running = (state_q == StRun);
  assign advance = running && zone_ext[SEQ[step_q]];
  assign trap    = zone_ext[TrapIdx];

`ifdef SEQ_MAZE_TIMEOUT_EN
  seq_maze_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run_i     (running),
    .clear_i   (advance),
    .expired_o (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    progress_d = progress_q;
    lap_d      = lap_q;
    step_d     = step_q;
    unique case (state_q)
      StRun: begin
        // Advance outranks both trap and timeout in the same cycle.
        if (advance) begin
          progress_d = progress_q + 1'b1;
          if (step_q == SW'(SEQ_LEN - 1)) begin
            step_d = '0;
            lap_d  = lap_q + 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
          if (progress_q == PW'(Total - 1)) begin
            state_d = StDone;
          end
        end else if (trap) begin
          state_d = StTrapped;
        end else if (expired) begin
          state_d = StFailed;
        end
      end
      StDone: begin
        if (trap) begin
          state_d = StTrapped;
        end
      end
      default: begin
        // Trapped and failed are absorbing.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      progress_q <= '0;
      lap_q      <= '0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      lap_q      <= lap_d;
      step_q     <= step_d;
    end
  end

  assign bus.objective = (state_q == StDone);
`ifdef SEQ_MAZE_TIMEOUT_EN
  assign bus.error     = (state_q == StTrapped) || (state_q == StFailed);
`else
  assign bus.error     = (state_q == StTrapped);
`endif
  assign bus.progress  = progress_q;
  assign bus.lap       = lap_q;

endmodule
